// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low gfedcba codes, reader FSM states, digit-select helpers.
package seg7_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } state_t;

    // True when exactly one select line is active.
    function automatic logic is_onehot(input logic [MAX_DIGITS-1:0] sel);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            ones = ones + 32'(sel[i]);
        end
        return (ones == 1);
    endfunction

    // Index of the active select line; only meaningful when is_onehot() holds.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_DIGITS-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (sel[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Reverse lookup of an active-low gfedcba pattern into a hex nibble plus legal/blank flags.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]    pat,
    output logic                legal_c,
    output logic                blank_c,
    output logic [NIBBLE_W-1:0] nibble_c
);

    always_comb begin
        legal_c  = 1'b1;
        blank_c  = 1'b0;
        nibble_c = '0;
        case (pat)
            SEG_0:     nibble_c = 4'h0;
            SEG_1:     nibble_c = 4'h1;
            SEG_2:     nibble_c = 4'h2;
            SEG_3:     nibble_c = 4'h3;
            SEG_4:     nibble_c = 4'h4;
            SEG_5:     nibble_c = 4'h5;
            SEG_6:     nibble_c = 4'h6;
            SEG_7:     nibble_c = 4'h7;
            SEG_8:     nibble_c = 4'h8;
            SEG_9:     nibble_c = 4'h9;
            SEG_A:     nibble_c = 4'hA;
            SEG_B:     nibble_c = 4'hB;
            SEG_C:     nibble_c = 4'hC;
            SEG_D:     nibble_c = 4'hD;
            SEG_E:     nibble_c = 4'hE;
            SEG_F:     nibble_c = 4'hF;
            SEG_BLANK: begin
                legal_c = 1'b0;
                blank_c = 1'b1;
            end
            default:   legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Multiplexed 7-seg bus read-back: debounces each digit's pattern and rebuilds the shown hex value.
// Define SEG7_READER_SYNC_EN to add 2-flop input synchronisers for off-chip sources.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         RST,
    input  logic [SEG_W-1:0]             SEG,
    input  logic [DIGITS-1:0]            DIG_SEL,
    input  logic                         CLR_ERR,
    output logic [NIBBLE_W*DIGITS-1:0]   VALUE,
    output logic [DIGITS-1:0]            DIG_VALID,
    output logic                         UPDATE,
    output logic                         ERR,
    output logic [SEG_W-1:0]             BAD_PAT
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]  seg_s;
    logic [DIGITS-1:0] sel_s;

`ifdef SEG7_READER_SYNC_EN
    logic [SEG_W-1:0]  seg_m;
    logic [DIGITS-1:0] sel_m;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            seg_m <= SEG_BLANK;
            seg_s <= SEG_BLANK;
            sel_m <= '0;
            sel_s <= '0;
        end else begin
            seg_m <= SEG;
            seg_s <= seg_m;
            sel_m <= DIG_SEL;
            sel_s <= sel_m;
        end
    end
`else
    assign seg_s = SEG;
    assign sel_s = DIG_SEL;
`endif

    // Current and previous samples of the bus; the FSM compares them each cycle.
    logic [SEG_W-1:0]  smp_seg, prv_seg;
    logic [DIGITS-1:0] smp_sel, prv_sel;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            smp_seg <= SEG_BLANK;
            prv_seg <= SEG_BLANK;
            smp_sel <= '0;
            prv_sel <= '0;
        end else begin
            smp_seg <= seg_s;
            prv_seg <= smp_seg;
            smp_sel <= sel_s;
            prv_sel <= smp_sel;
        end
    end

    logic             onehot_c;
    logic             same_c;
    logic [IDX_W-1:0] idx_c;

    assign onehot_c = is_onehot(MAX_DIGITS'(smp_sel));
    assign idx_c    = onehot_idx(MAX_DIGITS'(smp_sel));
    assign same_c   = (smp_seg == prv_seg) && (smp_sel == prv_sel);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit_c;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A run commits once, on the cycle its count reaches STABLE_CYCLES.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (onehot_c) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (!onehot_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same_c) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_d >= CNT_MAX) begin
                        state_d  = HELD;
                        commit_c = 1'b1;
                    end
                end
            end
            HELD: begin
                if (!onehot_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same_c) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    logic                legal_c;
    logic                blank_c;
    logic [NIBBLE_W-1:0] nibble_c;

    seg7_pattern_lookup u_lookup (
        .pat      (smp_seg),
        .legal_c  (legal_c),
        .blank_c  (blank_c),
        .nibble_c (nibble_c)
    );

    logic [DIGITS-1:0][NIBBLE_W-1:0] value_q;
    logic [DIGITS-1:0]               valid_q;
    logic                            update_q;
    logic                            err_q;
    logic [SEG_W-1:0]                bad_q;

    // Only the selected digit is touched; a new illegal commit overrides a same-cycle clear.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            value_q  <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            bad_q    <= '0;
        end else begin
            update_q <= 1'b0;
            if (CLR_ERR) begin
                err_q <= 1'b0;
                bad_q <= '0;
            end
            if (commit_c) begin
                if (legal_c) begin
                    update_q <= 1'b1;
                end else if (!blank_c) begin
                    err_q <= 1'b1;
                    bad_q <= smp_seg;
                end
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_c == IDX_W'(i)) begin
                        if (legal_c) begin
                            value_q[i] <= nibble_c;
                            valid_q[i] <= 1'b1;
                        end else if (blank_c) begin
                            valid_q[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign VALUE     = value_q;
    assign DIG_VALID = valid_q;
    assign UPDATE    = update_q;
    assign ERR       = err_q;
    assign BAD_PAT   = bad_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: predicted commits are queued at drive time, checked on UPDATE.
module tb_seg7_reader;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned STABLE = 3;
`ifdef SEG7_READER_SYNC_EN
    localparam int unsigned LAT = STABLE + 3;
`else
    localparam int unsigned LAT = STABLE + 1;
`endif

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        clr_err;
    logic [15:0] value;
    logic [3:0]  dig_valid;
    logic        update;
    logic        err;
    logic [6:0]  bad_pat;

    seg7_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .CLOCK_50  (clk),
        .RST       (rst),
        .SEG       (seg),
        .DIG_SEL   (dig_sel),
        .CLR_ERR   (clr_err),
        .VALUE     (value),
        .DIG_VALID (dig_valid),
        .UPDATE    (update),
        .ERR       (err),
        .BAD_PAT   (bad_pat)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  valid;
    } exp_t;

    exp_t        sb[$];
    logic [6:0]  ref_tab [16];
    logic [15:0] m_value;
    logic [3:0]  m_valid;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Update the reference model for a stable run and queue the expected state on legal commits.
    task automatic predict(input logic [3:0] sel, input logic [6:0] pat);
        int idx;
        int nib;
        idx = 0;
        nib = -1;
        for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
        for (int i = 0; i < 16; i++) if (ref_tab[i] == pat) nib = i;
        if (nib >= 0) begin
            m_value[idx*4 +: 4] = 4'(nib);
            m_valid[idx]        = 1'b1;
            sb.push_back('{value: m_value, valid: m_valid});
        end else if (pat == 7'h7F) begin
            m_valid[idx] = 1'b0;
        end
    endtask

    // Present a pattern for n cycles, starting and ending just after a rising edge.
    task automatic show(input logic [3:0] sel, input logic [6:0] pat, input int n);
        if (n >= int'(STABLE) && $countones(sel) == 1) predict(sel, pat);
        dig_sel = sel;
        seg     = pat;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        show(4'b0000, 7'h7F, int'(LAT) + 3);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    // Scoreboard consumer: every UPDATE must match the next queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (update === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_update", 32'(update), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_value", 32'(value), 32'(e.value));
                    chk("sb_valid", 32'(dig_valid), 32'(e.valid));
                end
            end
        end
    end

    initial begin
        logic [6:0] scan [4];
        ref_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        scan    = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
        n_cmp   = 0;
        n_bad   = 0;
        m_value = '0;
        m_valid = '0;
        rst     = 1'b1;
        seg     = 7'h7F;
        dig_sel = '0;
        clr_err = 1'b0;

        // Reset values, then idle with no digit selected.
        #25;
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_valid", 32'(dig_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_value", 32'(value), 32'd0);
        chk("idle_valid", 32'(dig_valid), 32'd0);
        chk("idle_update", 32'(update), 32'd0);
        chk("idle_badpat", 32'(bad_pat), 32'd0);

        // Digit 0 shows '2': single UPDATE exactly LAT edges after presentation.
        @(posedge clk);
        #1;
        predict(4'b0001, 7'b0100100);
        dig_sel = 4'b0001;
        seg     = 7'b0100100;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t2_update_edge%0d", k), 32'(update), 32'(k == int'(LAT)));
        end
        chk("t2_nibble", 32'(value[3:0]), 32'h2);
        chk("t2_valid", 32'(dig_valid), 32'b0001);
        @(posedge clk);
        #1;

        // Short glitch of '0' is dropped; the following stable '1' commits on digit 2.
        show(4'b0100, 7'b1000000, 2);
        show(4'b0100, 7'b1111001, 3);
        settle();
        chk("t3_nibble2", 32'(value[11:8]), 32'h1);
        chk("t3_nibble0", 32'(value[3:0]), 32'h2);
        chk("t3_valid", 32'(dig_valid), 32'b0101);

        // Illegal pattern on digit 3: sticky error, digits untouched.
        show(4'b1000, 7'b1010101, 5);
        settle();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_badpat", 32'(bad_pat), 32'h55);
        chk("t4_value", 32'(value), 32'(m_value));
        chk("t4_valid", 32'(dig_valid), 32'(m_valid));
        pulse_clr();
        chk("t4_clr_err", 32'(err), 32'd0);
        chk("t4_clr_badpat", 32'(bad_pat), 32'd0);

        // Clear coincident with a new illegal commit: the new error wins.
        dig_sel = 4'b1000;
        seg     = 7'b0101010;
        repeat (LAT - 1) @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("t4_setwins_err", 32'(err), 32'd1);
        chk("t4_setwins_badpat", 32'(bad_pat), 32'h2A);
        settle();
        pulse_clr();
        chk("t4_final_clr", 32'(err), 32'd0);

        // Scan loop A, b, C, d three times, then blank digit 1.
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 4; d++) begin
                show(4'(1 << d), scan[d], 4);
            end
        end
        settle();
        chk("t5_value", 32'(value), 32'hDCBA);
        chk("t5_valid", 32'(dig_valid), 32'hF);
        show(4'b0010, 7'h7F, 4);
        settle();
        chk("t5_blank_valid", 32'(dig_valid), 32'b1101);
        chk("t5_blank_value", 32'(value), 32'hDCBA);
        chk("t5_blank_err", 32'(err), 32'd0);

        // Multi-hot select never commits.
        show(4'b0011, 7'b0010010, 5);
        settle();
        chk("t6_value", 32'(value), 32'hDCBA);
        chk("t6_valid", 32'(dig_valid), 32'b1101);
        chk("t6_err", 32'(err), 32'd0);

        // Asynchronous reset in the middle of a run.
        dig_sel = 4'b0001;
        seg     = 7'b1000000;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t1_async_value", 32'(value), 32'd0);
        chk("t1_async_valid", 32'(dig_valid), 32'd0);
        chk("t1_async_update", 32'(update), 32'd0);
        @(posedge clk);
        #1;
        dig_sel = '0;
        seg     = 7'h7F;
        rst     = 1'b0;
        m_value = '0;
        m_valid = '0;
        settle();
        chk("t1_post_value", 32'(value), 32'd0);
        chk("t1_post_valid", 32'(dig_valid), 32'd0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
